// File: rtl/td4_pkg.sv
// TD4 4-bit teaching CPU: opcode map, core state encoding and decode helpers.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // The four holes in the opcode map trap the core rather than act as NOPs.
  function automatic logic op_illegal(input logic [3:0] op);
    return (op == 4'b1000) || (op == 4'b1010) || (op == 4'b1100) || (op == 4'b1101);
  endfunction

endpackage

// File: rtl/td4_if.sv
// Fetch/port bundle around a TD4 core; master is the core side, slave the ROM/IO side.
interface td4_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W+3:0] instr;
  logic              instr_valid;
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] out;
  logic              out_strobe;
  logic              carry;
  logic              halted;

  modport master (output address, out, out_strobe, carry, halted,
                  input  instr, instr_valid, in);
  modport slave  (input  address, out, out_strobe, carry, halted,
                  output instr, instr_valid, in);
endinterface

// File: rtl/td4_src_mux.sv
// ALU source select: the addend fed alongside the immediate, chosen by opcode.
module td4_src_mux
  import td4_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] src
);

  // MOV-immediate, OUT-immediate and both jumps add the immediate to zero.
  always_comb begin
    src = '0;
    case (opcode)
      OP_ADD_A, OP_MOV_BA:           src = a;
      OP_MOV_AB, OP_ADD_B, OP_OUT_B: src = b;
      OP_IN_A, OP_IN_B:              src = in_data;
      default:                       src = '0;
    endcase
  end

endmodule

// File: rtl/td4_core.sv
// TD4 core: one instruction per valid RUN cycle, all architectural registers here,
// traps into HALT on an illegal opcode until reset.
module td4_core
  import td4_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W+3:0] instr,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              out_strobe,
  output logic              carry,
  output logic              halted
);

  logic [3:0]        opcode;
  logic [DATA_W-1:0] imm, src, a_q, b_q;
  logic [DATA_W:0]   sum;
  logic [ADDR_W-1:0] pc_q;
  state_t            state_q;
  logic              exec, jump;

  assign opcode = instr[DATA_W+3:DATA_W];
  assign imm    = instr[DATA_W-1:0];

  td4_src_mux #(.DATA_W(DATA_W)) u_src (
    .opcode  (opcode),
    .a       (a_q),
    .b       (b_q),
    .in_data (in),
    .src     (src)
  );

  assign sum  = {1'b0, src} + {1'b0, imm};
  assign exec = (state_q == ST_RUN) && instr_valid;
  // JNC looks at the carry left by the previous instruction, not its own sum.
  assign jump = (opcode == OP_JMP) || ((opcode == OP_JNC) && !carry);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pc_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      out        <= '0;
      carry      <= 1'b0;
      out_strobe <= 1'b0;
      state_q    <= ST_RUN;
    end else begin
      out_strobe <= 1'b0;
      if (exec) begin
        if (op_illegal(opcode)) begin
          state_q <= ST_HALT;
        end else begin
          carry <= sum[DATA_W];
          pc_q  <= jump ? imm[ADDR_W-1:0] : pc_q + ADDR_W'(1);
          case (opcode)
            OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_A: a_q <= sum[DATA_W-1:0];
            OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_B: b_q <= sum[DATA_W-1:0];
            OP_OUT_B, OP_OUT_IM: begin
              out        <= sum[DATA_W-1:0];
              out_strobe <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign address = pc_q;
  assign halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_td4_core.sv
// Directed bench for td4_core: default 4-bit core plus an 8-bit instance, ROMs in the bench.
module tb_td4_core;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic n_reset8 = 1'b0;
  int   checks = 0;
  int   passes = 0;

  td4_if #(.DATA_W(4), .ADDR_W(4)) bus ();
  td4_if #(.DATA_W(8), .ADDR_W(4)) bus8 ();

  logic [7:0]  rom  [16];
  logic [11:0] rom8 [16];
  logic [10:0] st4;
  logic [14:0] st8;

  assign bus.instr  = rom[bus.address];
  assign bus8.instr = rom8[bus8.address];
  assign st4 = {bus.address, bus.carry, bus.out, bus.out_strobe, bus.halted};
  assign st8 = {bus8.address, bus8.carry, bus8.out, bus8.out_strobe, bus8.halted};

  always #5 clk = ~clk;

  td4_core dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .address     (bus.address),
    .instr       (bus.instr),
    .instr_valid (bus.instr_valid),
    .in          (bus.in),
    .out         (bus.out),
    .out_strobe  (bus.out_strobe),
    .carry       (bus.carry),
    .halted      (bus.halted)
  );

  td4_core #(.DATA_W(8), .ADDR_W(4)) dut8 (
    .clk         (clk),
    .n_reset     (n_reset8),
    .address     (bus8.address),
    .instr       (bus8.instr),
    .instr_valid (bus8.instr_valid),
    .in          (bus8.in),
    .out         (bus8.out),
    .out_strobe  (bus8.out_strobe),
    .carry       (bus8.carry),
    .halted      (bus8.halted)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic reset4();
    n_reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic test_reset();
    step(2);
    checks++;
    if (st4 !== {4'h0, 1'b0, 4'h0, 1'b0, 1'b0})
      $display("FAIL reset4_state: got %b want %b", st4, {4'h0, 1'b0, 4'h0, 1'b0, 1'b0});
    else passes++;
    checks++;
    if (st8 !== {4'h0, 1'b0, 8'h00, 1'b0, 1'b0})
      $display("FAIL reset8_state: got %b want %b", st8, {4'h0, 1'b0, 8'h00, 1'b0, 1'b0});
    else passes++;
  endtask

  task automatic test_basic();
    int pulses;
    fill_rom(8'hF4);
    rom[0] = 8'h31; rom[1] = 8'h0F; rom[2] = 8'hE0; rom[3] = 8'hB5;
    reset4();
    step();
    checks++;
    if (st4 !== {4'h1, 1'b0, 4'h0, 1'b0, 1'b0}) $display("FAIL basic_mov: got %b", st4);
    else passes++;
    step();
    checks++;
    if (st4 !== {4'h2, 1'b1, 4'h0, 1'b0, 1'b0}) $display("FAIL basic_add_carry: got %b", st4);
    else passes++;
    step();
    checks++;
    if (st4 !== {4'h3, 1'b0, 4'h0, 1'b0, 1'b0}) $display("FAIL basic_jnc_not_taken: got %b", st4);
    else passes++;
    step();
    checks++;
    if (st4 !== {4'h4, 1'b0, 4'h5, 1'b1, 1'b0}) $display("FAIL basic_out: got %b", st4);
    else passes++;
    pulses = 0;
    repeat (5) begin
      step();
      if (bus.out_strobe) pulses++;
    end
    checks++;
    if (pulses != 0 || st4 !== {4'h4, 1'b0, 4'h5, 1'b0, 1'b0})
      $display("FAIL basic_single_strobe: extra pulses %0d want 0, state %b", pulses, st4);
    else passes++;
  endtask

  task automatic test_wide();
    for (int i = 0; i < 16; i++) rom8[i] = 12'hF06;
    rom8[0] = 12'h200; rom8[1] = 12'h001; rom8[2] = 12'h707;
    rom8[3] = 12'h400; rom8[4] = 12'h505; rom8[5] = 12'h900;
    bus8.in = 8'hFF;
    n_reset8 = 1'b0;
    @(negedge clk);
    n_reset8 = 1'b1;
    step();
    checks++;
    if (st8 !== {4'h1, 1'b0, 8'h00, 1'b0, 1'b0}) $display("FAIL wide_in: got %b", st8);
    else passes++;
    step();
    checks++;
    if (st8 !== {4'h2, 1'b1, 8'h00, 1'b0, 1'b0}) $display("FAIL wide_add_wrap: got %b", st8);
    else passes++;
    step();
    checks++;
    if (st8 !== {4'h3, 1'b0, 8'h00, 1'b0, 1'b0}) $display("FAIL wide_mov_clears_carry: got %b", st8);
    else passes++;
    step(3);
    checks++;
    if (st8 !== {4'h6, 1'b0, 8'h05, 1'b1, 1'b0}) $display("FAIL wide_a_zero_out: got %b", st8);
    else passes++;
  endtask

  task automatic test_stall();
    fill_rom(8'hF7);
    rom[0] = 8'h33; rom[1] = 8'h0E; rom[2] = 8'h40; rom[3] = 8'h90;
    rom[4] = 8'h0F; rom[5] = 8'h40; rom[6] = 8'h90;
    reset4();
    step(2);
    checks++;
    if (st4 !== {4'h2, 1'b1, 4'h0, 1'b0, 1'b0}) $display("FAIL stall_pre: got %b", st4);
    else passes++;
    bus.instr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (st4 !== {4'h2, 1'b1, 4'h0, 1'b0, 1'b0}) $display("FAIL stall_hold%0d: got %b", k, st4);
      else passes++;
    end
    bus.instr_valid = 1'b1;
    step();
    checks++;
    if (st4 !== {4'h3, 1'b0, 4'h0, 1'b0, 1'b0}) $display("FAIL stall_resume: got %b", st4);
    else passes++;
    step();
    checks++;
    if (st4 !== {4'h4, 1'b0, 4'h1, 1'b1, 1'b0}) $display("FAIL stall_out_b: got %b", st4);
    else passes++;
    step(3);
    checks++;
    if (st4 !== {4'h7, 1'b0, 4'h0, 1'b1, 1'b0}) $display("FAIL stall_out_b2: got %b", st4);
    else passes++;
  endtask

  task automatic test_illegal();
    fill_rom(8'hBF);
    rom[0] = 8'hBA; rom[1] = 8'h3F; rom[2] = 8'h73;
    rom[3] = 8'h02; rom[4] = 8'h0F; rom[5] = 8'hD0;
    reset4();
    step(5);
    checks++;
    if (st4 !== {4'h5, 1'b1, 4'hA, 1'b0, 1'b0}) $display("FAIL illegal_pre: got %b", st4);
    else passes++;
    step();
    checks++;
    if (st4 !== {4'h5, 1'b1, 4'hA, 1'b0, 1'b1}) $display("FAIL illegal_halt: got %b", st4);
    else passes++;
    bus.instr_valid = 1'b0;
    step();
    bus.instr_valid = 1'b1;
    step(2);
    checks++;
    if (st4 !== {4'h5, 1'b1, 4'hA, 1'b0, 1'b1}) $display("FAIL halt_hold: got %b", st4);
    else passes++;
    n_reset = 1'b0;
    #1;
    checks++;
    if (st4 !== {4'h0, 1'b0, 4'h0, 1'b0, 1'b0}) $display("FAIL halt_reset: got %b", st4);
    else passes++;
    @(negedge clk);
    n_reset = 1'b1;
    step();
    checks++;
    if (st4 !== {4'h1, 1'b0, 4'hA, 1'b1, 1'b0}) $display("FAIL illegal_restart: got %b", st4);
    else passes++;
  endtask

  task automatic test_ramen();
    logic [3:0] seq [40];
    int n, bad;
    bit done;
    rom = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
            8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};
    bus.in = 4'b0101;
    reset4();
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      step();
      if (bus.out_strobe) begin
        if (n < 40) seq[n] = bus.out;
        n++;
        if (bus.out == 4'h8) done = 1'b1;
      end
    end
    checks++;
    if (!done) $display("FAIL ramen_timeout: no out=1000 within 2000 cycles (%0d outs)", n);
    else passes++;
    checks++;
    if (n != 35) $display("FAIL ramen_out_count: got %0d want 35", n);
    else passes++;
    if (n >= 35) begin
      checks++;
      if ({seq[0], seq[1], seq[2], seq[3], seq[34]} !== {4'h7, 4'h6, 4'h0, 4'h4, 4'h8})
        $display("FAIL ramen_seq: got %h %h %h %h .. %h want 7 6 0 4 .. 8",
                 seq[0], seq[1], seq[2], seq[3], seq[34]);
      else passes++;
      bad = 0;
      for (int i = 2; i < 34; i++)
        if (seq[i] !== ((i % 2 == 0) ? 4'h0 : 4'h4)) bad++;
      checks++;
      if (bad != 0) $display("FAIL ramen_alternate: got %0d bad entries want 0", bad);
      else passes++;
    end
    step(4);
    checks++;
    if (st4 !== {4'hF, 1'b0, 4'h8, 1'b0, 1'b0}) $display("FAIL ramen_jmp_loop: got %b", st4);
    else passes++;
  endtask

  task automatic test_async_reset();
    fill_rom(8'hF2);
    rom[0] = 8'h7F; rom[1] = 8'h9C;
    reset4();
    step(2);
    checks++;
    if (st4 !== {4'h2, 1'b1, 4'hB, 1'b1, 1'b0}) $display("FAIL async_pre: got %b", st4);
    else passes++;
    #2;
    n_reset = 1'b0;
    #1;
    checks++;
    if (st4 !== {4'h0, 1'b0, 4'h0, 1'b0, 1'b0}) $display("FAIL async_clear: got %b", st4);
    else passes++;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    n_reset = 1'b1;
    step();
    checks++;
    if (st4 !== {4'h0, 1'b0, 4'h0, 1'b0, 1'b0}) $display("FAIL async_no_strobe: got %b", st4);
    else passes++;
    bus.instr_valid = 1'b1;
  endtask

  initial begin
    bus.instr_valid  = 1'b1;
    bus.in           = 4'h0;
    bus8.instr_valid = 1'b1;
    bus8.in          = 8'h00;
    fill_rom(8'hF0);
    for (int i = 0; i < 16; i++) rom8[i] = 12'hF00;
    test_reset();
    test_basic();
    test_wide();
    test_stall();
    test_illegal();
    test_ramen();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
